// File: rtl/run_limited_serializer_pkg.sv
// Shared types and default parameters for the run-limited serializer.
package ser_pkg;

   localparam int DATA_W_DEF   = 8;
   localparam int RUN_MAX_DEF  = 3;
   localparam int MARK_LEN_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      STUFF = 2'd2,
      MARK  = 2'd3
   } ser_state_t;

   // The marker must be the only run longer than RUN_MAX, so RUN_MAX < MARK_LEN.
   function automatic bit params_ok(input int run_max, input int mark_len);
      return (run_max >= 1) && (run_max < mark_len);
   endfunction

endpackage

// File: rtl/run_limited_serializer_if.sv
// Request/serial-output bundle between a word source and the serializer.
interface run_limited_serializer_if #(
   parameter int DATA_W = ser_pkg::DATA_W_DEF
);
   logic [DATA_W-1:0] data_in;
   logic              data_valid;
   logic              mark_req;
   logic              data_ready;
   logic              w;
   logic              w_valid;
   logic              busy;

   modport master (
      output data_in, data_valid, mark_req,
      input  data_ready, w, w_valid, busy
   );

   modport slave (
      input  data_in, data_valid, mark_req,
      output data_ready, w, w_valid, busy
   );
endinterface

// File: rtl/run_limited_serializer_run_tracker.sv
// Tracks the last emitted stream bit and the length of the current run of equal bits.
module run_tracker
   import ser_pkg::*;
#(
   parameter int RUN_MAX  = RUN_MAX_DEF,
   parameter int MARK_LEN = MARK_LEN_DEF
) (
   input  logic Clk,
   input  logic reset,
   input  logic bit_in,
   input  logic bit_en,
   input  logic force_load,
   output logic last_bit,
   output logic need_stuff
);

   localparam int RUN_W = $clog2(MARK_LEN + 1);

   logic             last_bit_q, last_bit_d;
   logic [RUN_W-1:0] run_q, run_d;

   always_comb begin
      last_bit_d = last_bit_q;
      run_d      = run_q;
      if (force_load) begin
         last_bit_d = bit_in;
         run_d      = RUN_W'(1);
      end else if (bit_en) begin
         last_bit_d = bit_in;
         if (bit_in != last_bit_q) begin
            run_d = RUN_W'(1);
         end else if (run_q < RUN_W'(RUN_MAX)) begin
            run_d = run_q + RUN_W'(1);
         end
      end
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         last_bit_q <= 1'b0;
         run_q      <= '0;
      end else begin
         last_bit_q <= last_bit_d;
         run_q      <= run_d;
      end
   end

   assign last_bit   = last_bit_q;
   assign need_stuff = (run_q == RUN_W'(RUN_MAX));

endmodule

// File: rtl/run_limited_serializer.sv
// MSB-first word serializer with complement bit stuffing and a frame marker.
// state | meaning
// IDLE  | no stream bit on w; data_ready high, accepts marker or word
// DATA  | w carries a data bit from the shift register
// STUFF | w carries the complement stuff bit after RUN_MAX equal bits
// MARK  | w carries marker ones, then the terminating zero
module run_limited_serializer
   import ser_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int RUN_MAX  = RUN_MAX_DEF,
   parameter int MARK_LEN = MARK_LEN_DEF
) (
   input  logic                     Clk,
   input  logic                     reset,
   run_limited_serializer_if.slave  bus
);

   localparam int BL_W = $clog2(DATA_W + 1);
   localparam int MC_W = $clog2(MARK_LEN + 1);

   if (!params_ok(RUN_MAX, MARK_LEN)) begin : g_param_check
      $error("run_limited_serializer: RUN_MAX must be in 1..MARK_LEN-1");
   end

   ser_state_t        state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [BL_W-1:0]   bits_left_q, bits_left_d;
   logic [MC_W-1:0]   mark_cnt_q, mark_cnt_d;
   logic              w_q, w_d;
   logic              w_valid_q, w_valid_d;
   logic              busy_q, busy_d;

   logic              trk_bit, trk_en, trk_load;
   logic              last_bit, need_stuff;
   logic              launch_data;

   run_tracker #(
      .RUN_MAX  (RUN_MAX),
      .MARK_LEN (MARK_LEN)
   ) u_trk (
      .Clk        (Clk),
      .reset      (reset),
      .bit_in     (trk_bit),
      .bit_en     (trk_en),
      .force_load (trk_load),
      .last_bit   (last_bit),
      .need_stuff (need_stuff)
   );

   // state_q names the kind of bit currently on w; each edge launches the next bit.
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bits_left_d = bits_left_q;
      mark_cnt_d  = mark_cnt_q;
      w_d         = w_q;
      w_valid_d   = 1'b0;
      trk_bit     = 1'b0;
      trk_en      = 1'b0;
      trk_load    = 1'b0;
      launch_data = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.mark_req) begin
               state_d    = MARK;
               w_d        = 1'b1;
               w_valid_d  = 1'b1;
               mark_cnt_d = MC_W'(MARK_LEN);
            end else if (bus.data_valid) begin
               state_d     = DATA;
               w_d         = bus.data_in[DATA_W-1];
               w_valid_d   = 1'b1;
               shreg_d     = bus.data_in << 1;
               bits_left_d = BL_W'(DATA_W - 1);
               trk_bit     = bus.data_in[DATA_W-1];
               trk_en      = 1'b1;
            end
         end
         DATA: begin
            if (need_stuff) begin
               state_d   = STUFF;
               w_d       = ~last_bit;
               w_valid_d = 1'b1;
               trk_bit   = ~last_bit;
               trk_load  = 1'b1;
            end else if (bits_left_q != '0) begin
               launch_data = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         STUFF: begin
            if (bits_left_q != '0) begin
               launch_data = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         MARK: begin
            if (mark_cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               // Count 1 launches the terminator; the tracker restarts on that zero.
               w_d        = (mark_cnt_q != MC_W'(1));
               w_valid_d  = 1'b1;
               mark_cnt_d = mark_cnt_q - MC_W'(1);
               if (mark_cnt_q == MC_W'(1)) begin
                  trk_bit  = 1'b0;
                  trk_load = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (launch_data) begin
         state_d     = DATA;
         w_d         = shreg_q[DATA_W-1];
         w_valid_d   = 1'b1;
         shreg_d     = shreg_q << 1;
         bits_left_d = bits_left_q - BL_W'(1);
         trk_bit     = shreg_q[DATA_W-1];
         trk_en      = 1'b1;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         bits_left_q <= '0;
         mark_cnt_q  <= '0;
         w_q         <= 1'b0;
         w_valid_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bits_left_q <= bits_left_d;
         mark_cnt_q  <= mark_cnt_d;
         w_q         <= w_d;
         w_valid_q   <= w_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.w          = w_q;
   assign bus.w_valid    = w_valid_q;
   assign bus.busy       = busy_q;
   assign bus.data_ready = (state_q == IDLE) && !reset;

endmodule
